// File: rtl/obf_seqgen.sv
// ============================================================================
// obf_seqgen : expands one reference instruction into a LUT-driven sequence
// Rev 1.0
// ============================================================================
`default_nettype none

module obf_seqgen #(
   parameter int PPC_WIDTH     = 3,
   parameter int KEY_WIDTH     = 4,
   parameter int LUT_OUT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     obf_en_i,
   input  logic [KEY_WIDTH-1:0]     key_i,
   input  logic                     key_we_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [31:0]              in_insn_i,
   input  logic                     flush_i,
   output logic [5:0]               lut_idx_o,
   output logic [PPC_WIDTH-1:0]     lut_ppc_o,
   output logic [KEY_WIDTH-1:0]     lut_key_o,
   input  logic [LUT_OUT_WIDTH-1:0] lut_sub_i,
   input  logic [15:0]              lut_imm_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [31:0]              out_insn_o,
   output logic                     out_first_o,
   output logic                     out_last_o,
   output logic                     out_skip_o,
   output logic                     ovf_o
);

   localparam logic [5:0] c_opc_alu   = 6'h38;
   localparam logic [5:0] c_opc_sfxx  = 6'h39;
   localparam logic [5:0] c_opc_sfxxi = 6'h2F;
   localparam logic [5:0] c_opc_movhi = 6'h06;
   localparam logic [5:0] c_opc_rfe   = 6'h09;

   localparam logic [2:0] c_type_n  = 3'd0;
   localparam logic [2:0] c_type_a  = 3'd1;
   localparam logic [2:0] c_type_i  = 3'd2;
   localparam logic [2:0] c_type_m  = 3'd3;
   localparam logic [2:0] c_type_f  = 3'd4;
   localparam logic [2:0] c_type_fi = 3'd5;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            insn_q, insn_d;
   logic                   en_q, en_d;
   logic [PPC_WIDTH-1:0]   ppc_q, ppc_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [KEY_WIDTH-1:0]   pend_q, pend_d;
   logic                   pend_v_q, pend_v_d;
   logic                   ovf_q, ovf_d;

   logic                   w_run;
   logic                   w_ppc_max;
   logic                   w_lut_last;
   logic                   w_last;
   logic                   w_hs;
   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_seq_end;
   logic [2:0]             w_type;
   logic [11:0]            w_cmd;
   logic [5:0]             w_opc;
   logic [4:0]             w_rd, w_ra, w_rb;
   logic [4:0]             w_fd, w_fa, w_fb;
   logic [15:0]            w_src_imm, w_fi;
   logic [31:0]            w_word;
   logic                   w_skip;

   assign w_run      = (state_q == S_RUN);
   assign w_type     = lut_sub_i[LUT_OUT_WIDTH-1 -: 3];
   assign w_cmd      = lut_sub_i[12:1];
   assign w_lut_last = lut_sub_i[0];
   assign w_ppc_max  = (ppc_q == {PPC_WIDTH{1'b1}});

   // At the last pseudo-PC slot the sequence is cut short whatever the LUT says.
   assign w_last     = en_q ? (w_lut_last | w_ppc_max) : 1'b1;
   assign w_hs       = w_run & out_ready_i;
   assign w_in_ready = !flush_i & (!w_run | (w_hs & w_last));
   assign w_accept   = in_valid_i & w_in_ready;
   assign w_seq_end  = w_run & (flush_i | (w_hs & w_last));

   assign w_opc = insn_q[31:26];
   assign w_rd  = insn_q[25:21];
   assign w_ra  = insn_q[20:16];
   assign w_rb  = insn_q[15:11];

   always_comb begin
      w_fd      = w_cmd[3] ? 5'd0 : w_rd;
      w_fa      = 5'd0;
      w_fb      = 5'd0;
      w_src_imm = {w_rd, insn_q[10:0]};
      w_word    = insn_q;
      w_skip    = 1'b0;

      case (w_cmd[2:1])
         2'b00:   w_fa = w_ra;
         2'b01:   w_fa = w_rb;
         2'b10:   w_fa = w_rd;
         default: w_fa = 5'd0;
      endcase

      if ((w_type == c_type_f) || (w_type == c_type_fi)) begin
         case (w_cmd[4:3])
            2'b00:   w_fb = w_ra;
            2'b01:   w_fb = w_rb;
            default: w_fb = 5'd0;
         endcase
      end else begin
         w_fb = w_cmd[0] ? 5'd0 : w_rb;
      end

      if ((w_opc[5:4] == 2'b10) || (w_opc == c_opc_movhi) || (w_opc == c_opc_rfe))
         w_src_imm = insn_q[15:0];

      w_fi = w_cmd[5] ? lut_imm_i : (w_cmd[4] ? 16'd0 : w_src_imm);

      case (w_type)
         c_type_a:  w_word = {c_opc_alu, w_fd, w_fa, w_fb, 1'b0, w_cmd[11:8], 2'b00, w_cmd[7:4]};
         c_type_i:  w_word = {w_cmd[11:6], w_fd, w_fa, w_fi};
         c_type_m:  w_word = {w_cmd[11:6], w_fi[15:11], w_fa, w_fb, w_fi[10:0]};
         c_type_f:  w_word = {c_opc_sfxx, w_cmd[11:7], w_fa, w_fb, 11'd0};
         c_type_fi: w_word = {c_opc_sfxxi, w_cmd[11:7], w_fa, w_fi};
         default:   w_word = insn_q;
      endcase

      if ((w_type == c_type_i) || (w_type == c_type_m))
         w_skip = w_cmd[5];

      if (!en_q) begin
         w_word = insn_q;
         w_skip = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      insn_d   = insn_q;
      en_d     = en_q;
      ppc_d    = ppc_q;
      key_d    = key_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      ovf_d    = ovf_q;

      if (flush_i) begin
         state_d = S_IDLE;
         ppc_d   = '0;
      end else if (w_accept) begin
         state_d = S_RUN;
         insn_d  = in_insn_i;
         en_d    = obf_en_i;
         ppc_d   = '0;
      end else if (w_hs && w_last) begin
         state_d = S_IDLE;
         ppc_d   = '0;
      end else if (w_hs) begin
         ppc_d   = ppc_q + 1'b1;
      end

      if (!flush_i && w_hs && en_q && w_ppc_max && !w_lut_last)
         ovf_d = 1'b1;

      // Pending key lands at sequence end; a write in that same cycle overrides it
      // unless a new sequence is starting, in which case it waits for that one.
      if (w_seq_end && pend_v_q) begin
         key_d    = pend_q;
         pend_v_d = 1'b0;
      end
      if (key_we_i) begin
         if (!w_accept && (!w_run || w_seq_end)) begin
            key_d = key_i;
         end else begin
            pend_d   = key_i;
            pend_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         insn_q   <= '0;
         en_q     <= 1'b0;
         ppc_q    <= '0;
         key_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         insn_q   <= insn_d;
         en_q     <= en_d;
         ppc_q    <= ppc_d;
         key_q    <= key_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready_o  = w_in_ready;
   assign lut_idx_o   = insn_q[31:26];
   assign lut_ppc_o   = ppc_q;
   assign lut_key_o   = key_q;
   assign out_valid_o = w_run;
   assign out_insn_o  = w_run ? w_word : 32'd0;
   assign out_first_o = w_run & (!en_q | (ppc_q == '0));
   assign out_last_o  = w_run & w_last;
   assign out_skip_o  = w_run & w_skip;
   assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_obf_seqgen.sv
// Directed bench for obf_seqgen: main instance (PPC_WIDTH=3) plus a
// PPC_WIDTH=2 instance for the sequence-overflow case.
`default_nettype none

module tb_obf_seqgen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        obf_en, key_we, in_valid, in_valid2, flush, out_ready;
   logic [3:0]  key;
   logic [31:0] insn;
   logic [15:0] imm;
   logic [15:0] tab [8];

   logic        in_ready, out_valid, first, last, skip, ovf;
   logic [5:0]  lut_idx;
   logic [2:0]  lut_ppc;
   logic [3:0]  lut_key;
   logic [15:0] lut_sub;
   logic [31:0] out_insn;

   logic        in_ready2, out_valid2, first2, last2, skip2, ovf2;
   logic [5:0]  lut_idx2;
   logic [1:0]  lut_ppc2;
   logic [3:0]  lut_key2;
   logic [15:0] lut_sub2;
   logic [31:0] out_insn2;

   int total = 0;
   int bad   = 0;

   assign lut_sub  = tab[lut_ppc];
   assign lut_sub2 = tab[{1'b0, lut_ppc2}];

   always #5 clk = ~clk;

   obf_seqgen #(.PPC_WIDTH(3), .KEY_WIDTH(4), .LUT_OUT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .obf_en_i(obf_en), .key_i(key), .key_we_i(key_we),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_insn_i(insn), .flush_i(flush),
      .lut_idx_o(lut_idx), .lut_ppc_o(lut_ppc), .lut_key_o(lut_key),
      .lut_sub_i(lut_sub), .lut_imm_i(imm),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_insn_o(out_insn),
      .out_first_o(first), .out_last_o(last), .out_skip_o(skip), .ovf_o(ovf));

   obf_seqgen #(.PPC_WIDTH(2), .KEY_WIDTH(4), .LUT_OUT_WIDTH(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .obf_en_i(obf_en), .key_i(key), .key_we_i(key_we),
      .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_insn_i(insn), .flush_i(flush),
      .lut_idx_o(lut_idx2), .lut_ppc_o(lut_ppc2), .lut_key_o(lut_key2),
      .lut_sub_i(lut_sub2), .lut_imm_i(imm),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_insn_o(out_insn2),
      .out_first_o(first2), .out_last_o(last2), .out_skip_o(skip2), .ovf_o(ovf2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      obf_en = 0; key = 0; key_we = 0; in_valid = 0; in_valid2 = 0;
      insn = 0; flush = 0; out_ready = 0; imm = 16'hBEEF;
      for (int i = 0; i < 8; i++) tab[i] = 16'h0001;

      // reset state
      rst_n = 0;
      #3;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_insn", out_insn, 32'd0);
      chk("rst_flags", {29'd0, first, last, skip}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_key", {28'd0, lut_key}, 32'd0);
      chk("rst_ppc", {29'd0, lut_ppc}, 32'd0);
      tick(); tick();
      rst_n = 1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // bypass, back-to-back
      obf_en = 0; insn = 32'h9C210004; in_valid = 1; out_ready = 1;
      #1;
      chk("byp_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      insn = 32'h12345678;
      #1;
      chk("byp_valid", {31'd0, out_valid}, 32'd1);
      chk("byp_insn", out_insn, 32'h9C210004);
      chk("byp_flags", {29'd0, first, last, skip}, 32'd6);
      chk("byp_idx", {26'd0, lut_idx}, 32'h27);
      chk("byp_ready_last", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      #1;
      chk("byp2_insn", out_insn, 32'h12345678);
      chk("byp2_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("byp_idle", {31'd0, out_valid}, 32'd0);

      // 3-word sequence with a stall
      tab[0] = 16'h2744; tab[1] = 16'h5398; tab[2] = 16'h0001;
      obf_en = 1; insn = 32'hE0A41800; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0; obf_en = 0;
      #1;
      chk("s3_ppc0", {29'd0, lut_ppc}, 32'd0);
      chk("s3_w0", out_insn, 32'hE0A318CA);
      chk("s3_f0", {29'd0, first, last, skip}, 32'd4);
      chk("s3_ready0", {31'd0, in_ready}, 32'd0);
      chk("s3_idx", {26'd0, lut_idx}, 32'h38);
      tick();
      out_ready = 0;
      #1;
      chk("s3_ppc1", {29'd0, lut_ppc}, 32'd1);
      chk("s3_w1", out_insn, 32'h9C052800);
      chk("s3_f1", {29'd0, first, last, skip}, 32'd0);
      tick();
      chk("s3_ppc1_hold", {29'd0, lut_ppc}, 32'd1);
      chk("s3_w1_hold", out_insn, 32'h9C052800);
      out_ready = 1;
      tick();
      chk("s3_ppc2", {29'd0, lut_ppc}, 32'd2);
      chk("s3_w2", out_insn, 32'hE0A41800);
      chk("s3_f2", {29'd0, first, last, skip}, 32'd2);
      chk("s3_ready2", {31'd0, in_ready}, 32'd1);
      tick();
      chk("s3_idle", {31'd0, out_valid}, 32'd0);

      // formatter types with immediate substitution, one held word
      tab[0] = 16'h53C1;
      obf_en = 1; in_valid = 1;
      tick();
      in_valid = 0; out_ready = 0;
      #1;
      chk("fmt_i", out_insn, 32'h9CA4BEEF);
      chk("fmt_i_flags", {29'd0, first, last, skip}, 32'd7);
      tab[0] = 16'h33C1; #1;
      chk("fmt_a", out_insn, 32'hE0A41A4E);
      chk("fmt_a_flags", {29'd0, first, last, skip}, 32'd6);
      tab[0] = 16'h73C1; #1;
      chk("fmt_m", out_insn, 32'h9EE41EEF);
      chk("fmt_m_flags", {29'd0, first, last, skip}, 32'd7);
      tab[0] = 16'h93C1; #1;
      chk("fmt_f", out_insn, 32'hE6642000);
      chk("fmt_f_flags", {29'd0, first, last, skip}, 32'd6);
      tab[0] = 16'hB3C1; #1;
      chk("fmt_fi", out_insn, 32'hBE64BEEF);
      tab[0] = 16'hF3C1; #1;
      chk("fmt_unk", out_insn, 32'hE0A41800);
      out_ready = 1;
      tick();
      chk("fmt_idle", {31'd0, out_valid}, 32'd0);

      // flush at ppc 1
      tab[0] = 16'h2744; tab[1] = 16'h5398; tab[2] = 16'h0001;
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      flush = 1; in_valid = 1;
      #1;
      chk("fl_ppc", {29'd0, lut_ppc}, 32'd1);
      chk("fl_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 0;
      #1;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_ppc0", {29'd0, lut_ppc}, 32'd0);
      chk("fl_ready_after", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      #1;
      chk("fl_restart_valid", {31'd0, out_valid}, 32'd1);
      chk("fl_restart_ppc", {29'd0, lut_ppc}, 32'd0);
      chk("fl_restart_first", {31'd0, first}, 32'd1);
      tick(); tick(); tick();
      chk("fl_done", {31'd0, out_valid}, 32'd0);

      // key: immediate in IDLE, deferred while running
      key_we = 1; key = 4'd3;
      #1;
      chk("key_not_yet", {28'd0, lut_key}, 32'd0);
      tick();
      key_we = 0;
      chk("key_idle", {28'd0, lut_key}, 32'd3);
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      key_we = 1; key = 4'd9;
      tick();
      key_we = 0;
      chk("key_ppc", {29'd0, lut_ppc}, 32'd2);
      chk("key_held", {28'd0, lut_key}, 32'd3);
      tick();
      chk("key_applied", {28'd0, lut_key}, 32'd9);
      chk("key_idle_valid", {31'd0, out_valid}, 32'd0);

      // overflow on the PPC_WIDTH=2 instance
      for (int i = 0; i < 4; i++) tab[i] = 16'h2744;
      obf_en = 1; in_valid2 = 1;
      tick();
      in_valid2 = 0;
      chk("ov_valid", {31'd0, out_valid2}, 32'd1);
      tick(); tick();
      chk("ov_ppc2_last", {30'd0, lut_ppc2, last2}, 32'h4);
      tick();
      chk("ov_ppc3", {30'd0, lut_ppc2}, 32'd3);
      chk("ov_last", {31'd0, last2}, 32'd1);
      chk("ov_pre", {31'd0, ovf2}, 32'd0);
      chk("ov_w3", out_insn2, 32'hE0A318CA);
      tick();
      chk("ov_set", {31'd0, ovf2}, 32'd1);
      chk("ov_idle", {31'd0, out_valid2}, 32'd0);
      chk("ov_main_clear", {31'd0, ovf}, 32'd0);
      obf_en = 0; in_valid2 = 1;
      tick();
      in_valid2 = 0;
      tick();
      chk("ov_sticky", {31'd0, ovf2}, 32'd1);

      // asynchronous reset mid-sequence
      obf_en = 1; in_valid = 1;
      tick();
      in_valid = 0;
      chk("ar_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("ar_valid0", {31'd0, out_valid}, 32'd0);
      chk("ar_key0", {28'd0, lut_key}, 32'd0);
      chk("ar_ovf0", {31'd0, ovf2}, 32'd0);
      chk("ar_insn0", out_insn, 32'd0);
      tick();
      rst_n = 1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/obf_seqgen.md
# obf_seqgen

Parametrised obfuscated-sequence generator for the or1200-obf fetch path. It accepts one reference instruction per handshake and emits a multi-word substitution sequence, one word per output handshake. The sequence is walked by an internal pseudo-PC and driven by an external substitution LUT. The block sits between the instruction fetch buffer and `or1200_ctrl` decode, and adds flush, deferred key update, sequence-overflow protection and full valid/ready flow control.

## Interface
Parameters:
- `PPC_WIDTH`, 3: pseudo-PC width; maximum sequence length is 2^PPC_WIDTH.
- `KEY_WIDTH`, 4: obfuscation key width.
- `LUT_OUT_WIDTH`, 16: LUT word width. Fields are `{type[2:0], cmd[11:0], last}`; type is the top 3 bits.

Ports:
- `clk` in 1: clock. One clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `obf_en_i` in 1: obfuscation enable, sampled at input accept.
- `key_i` in KEY_WIDTH: new key value.
- `key_we_i` in 1: key write strobe.
- `in_valid_i` in 1: reference instruction valid.
- `in_ready_o` out 1: block can accept an instruction.
- `in_insn_i` in 32: reference instruction.
- `flush_i` in 1: abort the current sequence (branch or exception).
- `lut_idx_o` out 6: LUT index, equal to the held instruction's `[31:26]`.
- `lut_ppc_o` out PPC_WIDTH: current pseudo-PC.
- `lut_key_o` out KEY_WIDTH: active key.
- `lut_sub_i` in LUT_OUT_WIDTH: combinational LUT substitution word.
- `lut_imm_i` in 16: combinational LUT immediate.
- `out_valid_o` out 1: output word valid.
- `out_ready_i` in 1: downstream accepts the word.
- `out_insn_o` out 32: obfuscated instruction.
- `out_first_o` out 1: word is at ppc 0.
- `out_last_o` out 1: final word of the sequence.
- `out_skip_o` out 1: word consumes a LUT immediate.
- `ovf_o` out 1: sticky sequence-overflow flag.

## Operation
- States:
  - IDLE: no held instruction.
  - RUN: instruction held, `out_valid_o`=1.
- Accept condition: `in_valid_i & in_ready_o`. On accept:
  - latch `in_insn_i` and `obf_en_i` into `en_q`;
  - set ppc=0;
  - go to RUN.
- `in_ready_o` = `!flush_i & (IDLE | (out_valid_o & out_ready_i & out_last_o))`. A new accept may coincide with the last output handshake.
- Output handshake (`out_valid_o & out_ready_i`):
  - if `out_last_o`: return to IDLE, or stay in RUN with ppc=0 if a new instruction is accepted in the same cycle;
  - otherwise: ppc += 1.
- Bypass when `en_q`=0:
  - `out_insn_o` = held instruction;
  - `out_first_o`=1, `out_last_o`=1, `out_skip_o`=0;
  - LUT inputs are ignored.
- Formatter when `en_q`=1 (combinational from the held instruction and the LUT outputs):
  - D = `cmd[3]` ? 0 : insn D.
  - A = insn A, B, D, or 0, selected by `cmd[2:1]` = 00, 01, 10, 11.
  - B, for F/FI types = insn A, B, or 0, selected by `cmd[4:3]`; for other types = `cmd[0]` ? 0 : insn B.
  - Source immediate = insn `[15:0]` if the source is I-type (opc[5:4]=10, MOVHI, RFE); otherwise `{insn[25:21], insn[10:0]}`.
  - I = `cmd[5]` ? `lut_imm_i` : (`cmd[4]` ? 0 : source immediate).
  - Output word by type:
    - N → held instruction.
    - A → `{ALU, D, A, B, 0, cmd[11:8], 00, cmd[7:4]}`.
    - I → `{cmd[11:6], D, A, I}`.
    - M → `{cmd[11:6], I[15:11], A, B, I[10:0]}`.
    - F → `{SFXX, cmd[11:7], A, B, 11'd0}`.
    - FI → `{SFXXI, cmd[11:7], A, I}`.
    - Unknown type codes → held instruction.
  - `out_skip_o` = `cmd[5]` when type is I or M, else 0.
- Overflow: if ppc = 2^PPC_WIDTH−1 and the LUT `last` bit is 0:
  - `out_last_o` is forced to 1;
  - `ovf_o` is set on that word's handshake;
  - `ovf_o` is cleared only by reset.
- Key update:
  - `key_we_i` in IDLE (with no accept in the same cycle) loads `key_i` on the next edge.
  - `key_we_i` while RUN, or coincident with an accept, is stored as pending, with the latest write winning. The pending value is applied at the edge that ends the sequence (last handshake or flush).
  - The active key is never changed mid-sequence.
- Flush: `flush_i` has priority over everything else.
  - Next state is IDLE, ppc=0, `out_valid_o`=0.
  - No accept occurs in a flush cycle.
  - A pending key is applied.
  - A handshake in the same cycle is discarded by the consumer.

## Timing
- Reset values:
  - `out_valid_o`=0; `in_ready_o`=1 once `rst_n` is high and `flush_i`=0.
  - ppc=0, key=0, `ovf_o`=0, pending key cleared.
  - `out_insn_o`, `out_first_o`, `out_last_o`, `out_skip_o` are 0 while `out_valid_o`=0.
- Latency: an instruction accepted at edge k appears with `out_valid_o`=1 after edge k.
- Throughput: one word per cycle while `out_ready_i`=1. A 1-word sequence back-to-back with new inputs sustains 1 instruction/cycle.
- Output stability: `out_*` is held stable while `out_valid_o & !out_ready_i`. This assumes the LUT is a pure function of `{idx, ppc, key}`.
- Reset asserted mid-sequence immediately returns the block to reset values (asynchronous).

## Test plan
- Bypass: `obf_en_i`=0, insn `0x9C210004` (addi) → exactly one word `0x9C210004` with first=1, last=1, skip=0, one cycle after accept.
- 3-word sequence: LUT returns last=0, 0, 1 for ppc 0..2; `out_ready_i` toggles 1,0,1,1 → `lut_ppc_o` follows 0,1,1,2; words are held during the stall; first=1 only at ppc 0; `in_ready_o` goes high in the last-handshake cycle.
- Immediate substitution: I-type, `cmd[5]`=1, `lut_imm_i`=`0xBEEF` → `out_insn_o[15:0]`=`0xBEEF`, `out_skip_o`=1. The same word as type A gives `out_skip_o`=0.
- Overflow: `PPC_WIDTH`=2, LUT last=0 always → 4 words, 4th has `out_last_o`=1, `ovf_o`=1 after its handshake; `ovf_o` stays 1 through later sequences.
- Flush: flush at ppc=1 of a 3-word sequence with `in_valid_i`=1 → `in_ready_o`=0 that cycle; `out_valid_o`=0 next cycle; the next accept restarts at ppc=0.
- Deferred key: key=3; `key_we_i` with `key_i`=9 at ppc=1 → `lut_key_o` stays 3 until the last handshake, then 9. A write in IDLE takes effect on the next edge.
